// File: rtl/spi_byte_tx.sv
// SPI master byte transmitter (mode 0, MSB first, chip select framed per byte).
// Takes one byte per data/sendEnable/sendBusy handshake from the frequency
// measurement core and serialises it. SCLK is derived from baseClk by an
// internal divider, so the whole block lives in the baseClk domain.
// Every output is driven straight from a flop, so none of them can glitch.

module spi_byte_tx #(
    parameter int unsigned CLK_DIV = 4,  // baseClk cycles per SCLK half-period (1..255)
    parameter int unsigned CS_GAP  = 2   // baseClk cycles of CS high after each byte (1..255)
) (
    input  logic       baseClk,
    input  logic       hard_Clr,
    input  logic [7:0] data,
    input  logic       sendEnable,
    output logic       sendBusy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       byte_done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    // Terminal counts for the divider and the chip-select gap counter.
    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

    state_e     state_q;
    // Bit 7 goes straight to spi_mosi on accept, so only the remaining 7 bits are held.
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] div_cnt_q;
    logic [7:0] gap_cnt_q;

    logic div_wrap;
    logic last_bit;

    assign div_wrap = (div_cnt_q == DivLast);
    assign last_bit = (bit_cnt_q == 3'd7);

    // Transfer FSM: accept a byte, shift it out on the divided clock, then hold CS high.
    always_ff @(posedge baseClk or posedge hard_Clr) begin
        if (hard_Clr) begin
            state_q   <= StIdle;
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= 8'd0;
            gap_cnt_q <= 8'd0;
            sendBusy  <= 1'b0;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_cs_n  <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            // byte_done is a single-cycle strobe; only the GAP exit raises it.
            byte_done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sendEnable) begin
                        shift_q   <= data[6:0];
                        spi_mosi  <= data[7];
                        spi_cs_n  <= 1'b0;
                        spi_sclk  <= 1'b0;
                        sendBusy  <= 1'b1;
                        bit_cnt_q <= 3'd0;
                        div_cnt_q <= 8'd0;
                        state_q   <= StShift;
                    end
                end

                StShift: begin
                    if (!div_wrap) begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end else begin
                        div_cnt_q <= 8'd0;
                        if (!spi_sclk) begin
                            // Rising edge: the slave samples the bit already on MOSI.
                            spi_sclk <= 1'b1;
                        end else begin
                            // Falling edge: move on to the next bit or close the frame.
                            spi_sclk  <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                spi_mosi  <= 1'b0;
                                spi_cs_n  <= 1'b1;
                                gap_cnt_q <= 8'd0;
                                state_q   <= StGap;
                            end else begin
                                spi_mosi <= shift_q[6];
                                shift_q  <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        gap_cnt_q <= 8'd0;
                        sendBusy  <= 1'b0;
                        byte_done <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Self-checking bench for spi_byte_tx: a table of single-byte transfers plus
// hand-written sequences for framing, handshake abuse, reset and fast clocking.
// Instance A runs CLK_DIV=4/CS_GAP=2, instance B runs CLK_DIV=1/CS_GAP=1.

module tb_spi_byte_tx;

    logic       baseClk = 1'b0;
    logic       hard_Clr;
    logic [7:0] data_a, data_b;
    logic       en_a, en_b;
    logic       busy [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       cs_n [2];
    logic       done [2];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    spi_byte_tx #(.CLK_DIV(4), .CS_GAP(2)) u_dut_a (
        .baseClk    (baseClk),
        .hard_Clr   (hard_Clr),
        .data       (data_a),
        .sendEnable (en_a),
        .sendBusy   (busy[0]),
        .spi_sclk   (sclk[0]),
        .spi_mosi   (mosi[0]),
        .spi_cs_n   (cs_n[0]),
        .byte_done  (done[0])
    );

    spi_byte_tx #(.CLK_DIV(1), .CS_GAP(1)) u_dut_b (
        .baseClk    (baseClk),
        .hard_Clr   (hard_Clr),
        .data       (data_b),
        .sendEnable (en_b),
        .sendBusy   (busy[1]),
        .spi_sclk   (sclk[1]),
        .spi_mosi   (mosi[1]),
        .spi_cs_n   (cs_n[1]),
        .byte_done  (done[1])
    );

    always #5 baseClk = ~baseClk;

    // Edge counter; monitor timestamps are the index of the edge that changed a signal.
    always @(posedge baseClk) cyc <= cyc + 1;

    // ---------------- slave model / protocol monitor (both instances) ----------------
    bit         p_busy [2];
    bit         p_sclk [2];
    bit         p_mosi [2];
    bit         p_done [2];
    bit         p_rose [2];
    bit         p_cs_n [2] = '{1'b1, 1'b1};
    int         t0 [2];
    int         starts [2];
    int         busy_len [2];
    int         cs_fall [2];
    int         cs_rise [2];
    int         cs_len [2];
    int         cs_high [2];
    int         cs_rises [2];
    int         rise_n [2];
    int         rise_rel [2][8];
    int         rx_cnt [2];
    logic [7:0] rx_sh [2];
    logic [7:0] rx_mem [2][32];
    int         rx_n [2];
    int         done_cnt [2];
    int         done_t [2];
    int         v_cs [2];
    int         v_mosi [2];
    int         v_done [2];

    always @(negedge baseClk) begin
        for (int k = 0; k < 2; k++) begin
            if (sclk[k] && cs_n[k]) v_cs[k]++;
            if (sclk[k] && !p_sclk[k] && (mosi[k] != p_mosi[k])) v_mosi[k]++;
            if (p_rose[k] && (k == 0) && (mosi[k] != p_mosi[k])) v_mosi[k]++;
            if (done[k] && p_done[k]) v_done[k]++;

            if (busy[k] && !p_busy[k]) begin
                t0[k]     = cyc;
                starts[k] = starts[k] + 1;
                rise_n[k] = 0;
            end
            if (!busy[k] && p_busy[k]) busy_len[k] = cyc - t0[k];

            if (!cs_n[k] && p_cs_n[k]) begin
                cs_fall[k] = cyc;
                cs_high[k] = cyc - cs_rise[k];
                rx_cnt[k]  = 0;
            end
            if (cs_n[k] && !p_cs_n[k]) begin
                cs_rise[k]  = cyc;
                cs_len[k]   = cyc - cs_fall[k];
                cs_rises[k] = cs_rises[k] + 1;
                if (rx_cnt[k] == 8 && rx_n[k] < 32) begin
                    rx_mem[k][rx_n[k]] = rx_sh[k];
                    rx_n[k] = rx_n[k] + 1;
                end
            end

            if (sclk[k] && !p_sclk[k]) begin
                rx_sh[k]  = {rx_sh[k][6:0], mosi[k]};
                rx_cnt[k] = rx_cnt[k] + 1;
                if (rise_n[k] < 8) rise_rel[k][rise_n[k]] = cyc - t0[k];
                rise_n[k] = rise_n[k] + 1;
            end

            if (done[k] && !p_done[k]) begin
                done_cnt[k] = done_cnt[k] + 1;
                done_t[k]   = cyc - t0[k];
            end

            p_rose[k] = sclk[k] && !p_sclk[k];
            p_busy[k] = busy[k];
            p_sclk[k] = sclk[k];
            p_mosi[k] = mosi[k];
            p_cs_n[k] = cs_n[k];
            p_done[k] = done[k];
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_busy(input int k, input logic lvl, input string nm);
        int n = 0;
        while (busy[k] !== lvl && n < 300) begin
            @(negedge baseClk);
            n++;
        end
        if (busy[k] !== lvl) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: timeout, busy stuck at %b want %b", nm, busy[k], lvl);
        end
    endtask

    task automatic wait_done(input int k, input string nm);
        int n = 0;
        while (!(done[k] === 1'b1 && busy[k] === 1'b0) && n < 300) begin
            @(negedge baseClk);
            n++;
        end
        if (!(done[k] === 1'b1 && busy[k] === 1'b0)) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: timeout, done=%b busy=%b want done=1 busy=0", nm, done[k], busy[k]);
        end
    endtask

    // Upstream model for instance A: present, drop after busy, wait for done.
    task automatic send_a(input logic [7:0] d, input int hold);
        data_a = d;
        en_a   = 1'b1;
        wait_busy(0, 1'b1, "a_accept");
        en_a   = 1'b0;
        data_a = ~d;
        wait_done(0, "a_done");
        repeat (hold) @(negedge baseClk);
    endtask

    typedef struct {
        logic [7:0] d;
        int         busy_cyc;
        int         cs_cyc;
        int         done_at;
        logic [7:0] rx;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] frame [5];
    int         r0, d0, c0, s0;

    initial begin
        vecs[0] = '{8'h00, 66, 64, 66, 8'h00};
        vecs[1] = '{8'hFF, 66, 64, 66, 8'hFF};
        vecs[2] = '{8'h3C, 66, 64, 66, 8'h3C};
        vecs[3] = '{8'h01, 66, 64, 66, 8'h01};
        vecs[4] = '{8'h80, 66, 64, 66, 8'h80};
        vecs[5] = '{8'h69, 66, 64, 66, 8'h69};
        frame   = '{8'hFF, 8'h78, 8'h56, 8'h34, 8'h12};

        hard_Clr = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        repeat (2) @(negedge baseClk);

        // Reset state of both instances.
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_sclk", int'(sclk[k]), 0);
            chk("rst_mosi", int'(mosi[k]), 0);
            chk("rst_cs_n", int'(cs_n[k]), 1);
            chk("rst_done", int'(done[k]), 0);
        end
        hard_Clr = 1'b0;
        repeat (2) @(negedge baseClk);

        // Single 0xA5 transfer: full timing picture.
        r0 = rx_n[0];
        send_a(8'hA5, 3);
        chk("t1_busy_len", busy_len[0], 66);
        chk("t1_cs_len", cs_len[0], 64);
        chk("t1_done_at", done_t[0], 66);
        chk("t1_rises", rise_n[0], 8);
        for (int j = 0; j < 8; j++) chk("t1_rise_time", rise_rel[0][j], 4 + 8 * j);
        chk("t1_rx_count", rx_n[0] - r0, 1);
        chk("t1_rx", int'(rx_mem[0][r0]), 8'hA5);
        chk("t1_done_cnt", done_cnt[0], 1);

        // Table of single-byte transfers.
        for (int i = 0; i < 6; i++) begin
            r0 = rx_n[0];
            send_a(vecs[i].d, 3);
            chk("vec_busy_len", busy_len[0], vecs[i].busy_cyc);
            chk("vec_cs_len", cs_len[0], vecs[i].cs_cyc);
            chk("vec_done_at", done_t[0], vecs[i].done_at);
            chk("vec_rx_count", rx_n[0] - r0, 1);
            chk("vec_rx", int'(rx_mem[0][r0]), int'(vecs[i].rx));
        end

        // Five-byte frame for baseCount=0x12345678, upstream presents as soon as done.
        r0 = rx_n[0]; d0 = done_cnt[0]; c0 = cs_rises[0];
        for (int j = 0; j < 5; j++) send_a(frame[j], 0);
        repeat (3) @(negedge baseClk);
        for (int j = 0; j < 5; j++) chk("frame_rx", int'(rx_mem[0][r0 + j]), int'(frame[j]));
        chk("frame_done_cnt", done_cnt[0] - d0, 5);
        chk("frame_cs_rises", cs_rises[0] - c0, 5);
        chk("frame_cs_gap", cs_high[0], 3);

        // Handshake abuse during SHIFT of 0x81.
        r0 = rx_n[0]; s0 = starts[0];
        data_a = 8'h81;
        en_a   = 1'b1;
        wait_busy(0, 1'b1, "t3_accept");
        for (int j = 0; j < 30; j++) begin
            en_a   = ~en_a;
            data_a = 8'h3C;
            @(negedge baseClk);
        end
        en_a = 1'b0;
        wait_done(0, "t3_done");
        repeat (5) @(negedge baseClk);
        chk("t3_rx", int'(rx_mem[0][r0]), 8'h81);
        chk("t3_starts", starts[0] - s0, 1);
        chk("t3_busy_len", busy_len[0], 66);

        // Reset mid-transfer of 0xF0, then 0x55.
        r0 = rx_n[0]; d0 = done_cnt[0];
        data_a = 8'hF0;
        en_a   = 1'b1;
        wait_busy(0, 1'b1, "t4_accept");
        en_a = 1'b0;
        repeat (24) @(negedge baseClk);
        hard_Clr = 1'b1;
        #1;
        chk("t4_rst_busy", int'(busy[0]), 0);
        chk("t4_rst_cs_n", int'(cs_n[0]), 1);
        chk("t4_rst_sclk", int'(sclk[0]), 0);
        chk("t4_rst_mosi", int'(mosi[0]), 0);
        chk("t4_rst_done", int'(done[0]), 0);
        repeat (3) @(negedge baseClk);
        hard_Clr = 1'b0;
        repeat (3) @(negedge baseClk);
        chk("t4_no_done", done_cnt[0] - d0, 0);
        chk("t4_no_rx", rx_n[0] - r0, 0);
        send_a(8'h55, 3);
        chk("t4_rx", int'(rx_mem[0][r0]), 8'h55);
        chk("t4_busy_len", busy_len[0], 66);

        // Fast instance, sendEnable held across two bytes.
        data_b = 8'hFF;
        en_b   = 1'b1;
        wait_busy(1, 1'b1, "t5_accept1");
        data_b = 8'h00;
        wait_busy(1, 1'b0, "t5_drop1");
        @(negedge baseClk);
        chk("t5_busy_len1", busy_len[1], 17);
        chk("t5_reaccept", int'(busy[1]), 1);
        en_b = 1'b0;
        wait_done(1, "t5_done2");
        repeat (3) @(negedge baseClk);
        chk("t5_busy_len2", busy_len[1], 17);
        chk("t5_cs_len", cs_len[1], 16);
        chk("t5_cs_gap", cs_high[1], 2);
        chk("t5_rx_count", rx_n[1], 2);
        chk("t5_rx0", int'(rx_mem[1][0]), 8'hFF);
        chk("t5_rx1", int'(rx_mem[1][1]), 8'h00);
        chk("t5_done_cnt", done_cnt[1], 2);

        // Protocol rules watched throughout the run.
        for (int k = 0; k < 2; k++) begin
            chk("chk_sclk_while_cs_high", v_cs[k], 0);
            chk("chk_mosi_near_rise", v_mosi[k], 0);
            chk("chk_done_width", v_done[k], 0);
        end
        chk("a_total_done", done_cnt[0], 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- Downstream stage of the frequency-measurement core.
- Consumes the byte stream (0xFF header, then baseCount LSB..MSB) through the data/sendEnable/sendBusy handshake.
- Shifts each byte out as an SPI master: mode 0, MSB first, chip-select framed per byte.
- Runs entirely in the baseClk domain; SCLK is derived by an internal divider.

Parameters:
- CLK_DIV, default 4: baseClk cycles per SCLK half-period. Legal range is 1..255.
- CS_GAP, default 2: baseClk cycles that spi_cs_n is held high after each byte, before sendBusy is released. Legal range is 1..255.

Ports:
- baseClk, input, 1: system clock. All logic is on the rising edge.
- hard_Clr, input, 1: reset, asynchronous, active-high.
- data, input, 8: byte to send. Sampled only on the accept edge.
- sendEnable, input, 1: transfer request, level-sensitive.
- sendBusy, output, 1: high while a byte is in flight, including the CS gap.
- spi_sclk, output, 1: SPI clock, CPOL=0.
- spi_mosi, output, 1: serial data, MSB first.
- spi_cs_n, output, 1: chip select, active-low.
- byte_done, output, 1: one-cycle pulse when a byte transfer completes.

Behaviour:
- Reset (async, any state): sendBusy=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, byte_done=0, FSM=IDLE, all counters=0. A byte in flight is discarded and no partial completion is signalled.
- FSM states: IDLE, SHIFT, GAP.

IDLE:
- Accept edge T0 is the first rising edge with sendEnable=1. On T0:
  - shift register <= data
  - sendBusy <= 1, spi_cs_n <= 0, spi_mosi <= data[7], spi_sclk stays 0
  - bit counter <= 0, divider <= 0
  - go to SHIFT
- sendEnable=0: hold all outputs at idle values.

SHIFT:
- The divider counts 0..CLK_DIV-1, and spi_sclk toggles on each divider wrap.
- spi_sclk rises at T0+(2i+1)*CLK_DIV for bit i = 0..7. The slave samples spi_mosi on these rising edges.
- spi_sclk falls at T0+(2i+2)*CLK_DIV. On each falling edge with i<7, the register shifts left and spi_mosi <= next bit. The bit counter increments on each falling edge.
- On the 8th falling edge (T0+16*CLK_DIV):
  - spi_sclk=0, spi_mosi<=0, spi_cs_n<=1
  - go to GAP

GAP:
- Count CS_GAP cycles.
- At T0+16*CLK_DIV+CS_GAP: sendBusy<=0, byte_done<=1 for exactly one cycle, go to IDLE.

Timing:
- sendBusy is high for exactly 16*CLK_DIV+CS_GAP cycles per byte.
- spi_cs_n is low for exactly 16*CLK_DIV cycles per byte.

Handshake rules:
- sendEnable is ignored outside IDLE. data may change freely after T0.
- The upstream stage drops sendEnable on the edge after it sees sendBusy=1, so each request is accepted exactly once.
- If sendEnable is still high when the FSM returns to IDLE, it is accepted on the next edge. Back-to-back bytes therefore have spi_cs_n high for CS_GAP+1 cycles.
- sendBusy=0 together with byte_done=1 is what allows the upstream stage to present its next byte.

Other rules:
- No glitches: every output is a register output.
- spi_sclk is never high while spi_cs_n=1.
- Counters: the divider is 8 bits and the bit counter is 3 bits. Wrap-around is defined only at the points stated above.

Test Plan:
1. CLK_DIV=4, CS_GAP=2; present data=0xA5 with sendEnable pulsed until busy is seen -> sendBusy high for 66 cycles; spi_cs_n low for 64 cycles; 8 SCLK rising edges at T0+4, T0+12, …, T0+60; MOSI sampled on those edges = 1,0,1,0,0,1,0,1; byte_done pulses once at T0+66.
2. Bus-functional upstream model replaying the 5-byte frame for baseCount=0x12345678 -> SPI slave model receives FF, 78, 56, 34, 12 in order; exactly 5 byte_done pulses; spi_cs_n toggles high between every byte.
3. Toggle sendEnable and data (0x3C) during SHIFT of a 0x81 transfer -> received byte is 0x81; no extra transfer starts; sendBusy waveform is unchanged.
4. Assert hard_Clr at T0+25 (mid bit 3) of a 0xF0 transfer -> all outputs return to idle values within the reset cycle (spi_cs_n=1, sclk=0, busy=0); no byte_done; after release, 0x55 transfers correctly.
5. CLK_DIV=1, CS_GAP=1; sendEnable held high continuously with data 0xFF, then 0x00 -> each byte busy for 17 cycles; spi_cs_n high for 2 cycles between bytes; received bytes are FF then 00.
6. Slave checker across all runs -> sclk=0 whenever spi_cs_n=1; MOSI never changes within ±1 cycle of an SCLK rising edge.
